m65c02_mpc_gen: RTL and testbench

Parametrised microprogram sequencer for the M65C02A core, successor to the F9408-style MPC. It sits between the microprogram ROM and the instruction/control decode logic, and computes the next microprogram address each microcycle. Over the previous generation it adds:
- a return stack of any depth, with sticky overflow/underflow flags;
- a hardware loop counter, with load and decrement-and-branch instructions;
- a 5-bit instruction field.

Microcycle length is set externally through Rdy.

---
 rtl/m65c02_mpc_pkg.sv | 32 +++
 rtl/m65c02_mpc_if.sv | 29 ++
 rtl/m65c02_mpc_stk.sv | 47 ++++
 rtl/m65c02_mpc_gen.sv | 100 ++++++++++
 tb/tb_m65c02_mpc_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/m65c02_mpc_pkg.sv
// Shared definitions for the M65C02A microprogram sequencer:
// microinstruction opcodes and the branch-address source (Via) encoding.
package m65c02_mpc_pkg;

    localparam logic [4:0] pRTS  = 5'd0;
    localparam logic [4:0] pBSR  = 5'd1;
    localparam logic [4:0] pFTCH = 5'd2;
    localparam logic [4:0] pBMW  = 5'd3;
    localparam logic [4:0] pBRV0 = 5'd4;
    localparam logic [4:0] pBRV1 = 5'd5;
    localparam logic [4:0] pBRV2 = 5'd6;
    localparam logic [4:0] pBRV3 = 5'd7;
    localparam logic [4:0] pBTH0 = 5'd8;
    localparam logic [4:0] pBTH1 = 5'd9;
    localparam logic [4:0] pBTH2 = 5'd10;
    localparam logic [4:0] pBTH3 = 5'd11;
    localparam logic [4:0] pBTL0 = 5'd12;
    localparam logic [4:0] pBTL1 = 5'd13;
    localparam logic [4:0] pBTL2 = 5'd14;
    localparam logic [4:0] pBMW3 = 5'd15;
    localparam logic [4:0] pLDC  = 5'd16;
    localparam logic [4:0] pDJNZ = 5'd17;

    // Via selects which external source supplies BA; VIA_0 is also the idle value.
    typedef enum logic [1:0] {
        VIA_0 = 2'd0,
        VIA_1 = 2'd1,
        VIA_2 = 2'd2,
        VIA_3 = 2'd3
    } via_e;

endpackage

// File: rtl/m65c02_mpc_if.sv
// Microcycle bus between the sequencer (slave) and the ROM/decode side (master).
interface m65c02_mpc_if #(
    parameter int pAddrWidth = 10,
    parameter int pStkDepth  = 4,
    parameter int pCntWidth  = 6
);
    logic                               Rdy;
    logic [4:0]                         I;
    logic [3:0]                         T;
    logic [2:0]                         MW;
    logic [pAddrWidth-1:0]              BA;
    logic [1:0]                         Via;
    logic [pAddrWidth-1:0]              MA;
    logic [pCntWidth-1:0]               Cnt;
    logic                               CntZ;
    logic [$clog2(pStkDepth+1)-1:0]     StkLvl;
    logic                               StkOvf;
    logic                               StkUnf;

    modport master (
        output Rdy, I, T, MW, BA,
        input  Via, MA, Cnt, CntZ, StkLvl, StkOvf, StkUnf
    );

    modport slave (
        input  Rdy, I, T, MW, BA,
        output Via, MA, Cnt, CntZ, StkLvl, StkOvf, StkUnf
    );
endinterface

// File: rtl/m65c02_mpc_stk.sv
// Shift-register return stack: push shifts down dropping the deepest entry,
// pop shifts up filling the bottom with zero; overflow/underflow are sticky.
module m65c02_mpc_stk #(
    parameter int pDepth = 4,
    parameter int pWidth = 10
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          i_Push,
    input  logic                          i_Pop,
    input  logic [pWidth-1:0]             i_D,
    output logic [pWidth-1:0]             o_TOS,
    output logic [$clog2(pDepth+1)-1:0]   o_Lvl,
    output logic                          o_Ovf,
    output logic                          o_Unf
);
    localparam int cLvlW = $clog2(pDepth+1);

    logic [pWidth-1:0] r_Stk [pDepth];
    logic [cLvlW-1:0]  r_Lvl;
    logic              r_Ovf;
    logic              r_Unf;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < pDepth; i++) r_Stk[i] <= '0;
            r_Lvl <= '0;
            r_Ovf <= 1'b0;
            r_Unf <= 1'b0;
        end else if (i_Push) begin
            r_Stk[0] <= i_D;
            for (int i = 1; i < pDepth; i++) r_Stk[i] <= r_Stk[i-1];
            if (r_Lvl == cLvlW'(pDepth)) r_Ovf <= 1'b1;
            else                         r_Lvl <= r_Lvl + cLvlW'(1);
        end else if (i_Pop) begin
            for (int i = 0; i < pDepth-1; i++) r_Stk[i] <= r_Stk[i+1];
            r_Stk[pDepth-1] <= '0;
            if (r_Lvl == '0) r_Unf <= 1'b1;
            else             r_Lvl <= r_Lvl - cLvlW'(1);
        end
    end

    assign o_TOS = r_Stk[0];
    assign o_Lvl = r_Lvl;
    assign o_Ovf = r_Ovf;
    assign o_Unf = r_Unf;
endmodule

// File: rtl/m65c02_mpc_gen.sv
// M65C02A microprogram sequencer: combinational next-address mux, PC,
// loop counter and return stack, with a one-cycle stretched internal reset.
module m65c02_mpc_gen
    import m65c02_mpc_pkg::*;
#(
    parameter int pAddrWidth = 10,
    parameter int pStkDepth  = 4,
    parameter int pCntWidth  = 6,
    parameter int pRst_Addrs = 0
) (
    input  logic            Clk,
    input  logic            Rst,
    m65c02_mpc_if.slave     bus
);
    localparam logic [pAddrWidth-1:0] cRstA = pAddrWidth'(pRst_Addrs);

    logic                  r_RstDly;
    logic                  w_MpcRst;
    logic [pAddrWidth-1:0] r_PC;
    logic [pAddrWidth-1:0] w_Next;
    logic [pAddrWidth-1:0] w_MA;
    via_e                  w_Via;
    logic [pAddrWidth-1:0] w_TOS;
    logic [pCntWidth-1:0]  r_Cnt;
    logic                  r_CntZ;
    logic                  w_Push;
    logic                  w_Pop;

    always_ff @(posedge Clk) r_RstDly <= Rst;

    assign w_MpcRst = Rst | r_RstDly;
    assign w_Next   = r_PC + pAddrWidth'(1);

    always_comb begin
        w_MA  = w_Next;
        w_Via = VIA_0;
        if (w_MpcRst) begin
            w_MA = cRstA;
        end else begin
            case (bus.I)
                pRTS:                       w_MA = w_TOS;
                pBSR:                       w_MA = bus.BA;
                pBMW:                       w_MA = {bus.BA[pAddrWidth-1:3], bus.MW};
                pBRV0, pBRV1, pBRV2, pBRV3: begin
                    w_MA  = bus.BA;
                    w_Via = via_e'(bus.I[1:0]);
                end
                pBTH0, pBTH1, pBTH2, pBTH3: w_MA = bus.T[bus.I[1:0]] ? bus.BA : w_Next;
                pBTL0, pBTL1, pBTL2:        w_MA = bus.T[bus.I[1:0]] ? w_Next : bus.BA;
                pBMW3:                      w_MA = {bus.BA[pAddrWidth-1:1], bus.T[3]};
                pDJNZ:                      w_MA = r_CntZ ? w_Next : bus.BA;
                default:                    w_MA = w_Next;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (w_MpcRst)     r_PC <= cRstA;
        else if (bus.Rdy) r_PC <= w_MA;
    end

    // CntZ is kept in step with Cnt so DJNZ decides without a compare on the count.
    always_ff @(posedge Clk) begin
        if (w_MpcRst) begin
            r_Cnt  <= '0;
            r_CntZ <= 1'b1;
        end else if (bus.Rdy) begin
            if (bus.I == pLDC) begin
                r_Cnt  <= bus.BA[pCntWidth-1:0];
                r_CntZ <= (bus.BA[pCntWidth-1:0] == '0);
            end else if ((bus.I == pDJNZ) && !r_CntZ) begin
                r_Cnt  <= r_Cnt - pCntWidth'(1);
                r_CntZ <= (r_Cnt == pCntWidth'(1));
            end
        end
    end

    assign w_Push = bus.Rdy & ~w_MpcRst & (bus.I == pBSR);
    assign w_Pop  = bus.Rdy & ~w_MpcRst & (bus.I == pRTS);

    m65c02_mpc_stk #(
        .pDepth (pStkDepth),
        .pWidth (pAddrWidth)
    ) u_stk (
        .Clk    (Clk),
        .Rst    (w_MpcRst),
        .i_Push (w_Push),
        .i_Pop  (w_Pop),
        .i_D    (w_Next),
        .o_TOS  (w_TOS),
        .o_Lvl  (bus.StkLvl),
        .o_Ovf  (bus.StkOvf),
        .o_Unf  (bus.StkUnf)
    );

    assign bus.MA   = w_MA;
    assign bus.Via  = w_Via;
    assign bus.Cnt  = r_Cnt;
    assign bus.CntZ = r_CntZ;
endmodule

// File: tb/tb_m65c02_mpc_gen.sv
// Randomised bench for m65c02_mpc_gen against a queue-based behavioural model,
// plus directed sequences with hand-computed expectations.
module tb_m65c02_mpc_gen;
    localparam int AW = 10;
    localparam int SD = 4;
    localparam int CW = 6;
    localparam int RA = 0;
    localparam int unsigned AMASK = (1 << AW) - 1;
    localparam int unsigned CMASK = (1 << CW) - 1;

    logic Clk;
    logic Rst;
    m65c02_mpc_if #(.pAddrWidth(AW), .pStkDepth(SD), .pCntWidth(CW)) bus();

    m65c02_mpc_gen #(.pAddrWidth(AW), .pStkDepth(SD), .pCntWidth(CW), .pRst_Addrs(RA)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    int unsigned m_pc, m_cnt;
    int unsigned m_stk[$];
    bit m_ovf, m_unf;
    bit m_rstd = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int unsigned exp_ma();
        int unsigned nxt  = (m_pc + 1) & AMASK;
        int unsigned ba   = 32'(bus.BA);
        int unsigned code = 32'(bus.I);
        logic [3:0]  t    = bus.T;
        if (Rst || m_rstd) return RA;
        if (code == 0) return (m_stk.size() != 0) ? m_stk[0] : 0;
        if (code == 1) return ba;
        if (code == 3) return (ba & ~32'd7) | 32'(bus.MW);
        if (code >= 4 && code <= 7) return ba;
        if (code >= 8 && code <= 11) return t[code-8] ? ba : nxt;
        if (code >= 12 && code <= 14) return t[code-12] ? nxt : ba;
        if (code == 15) return (ba & ~32'd1) | 32'(t[3]);
        if (code == 17) return (m_cnt != 0) ? ba : nxt;
        return nxt;
    endfunction

    function automatic int unsigned exp_via();
        int unsigned code = 32'(bus.I);
        if (Rst || m_rstd) return 0;
        return (code >= 4 && code <= 7) ? (code - 4) : 0;
    endfunction

    task automatic model_update();
        int unsigned ma   = exp_ma();
        int unsigned code = 32'(bus.I);
        if (Rst || m_rstd) begin
            m_pc = RA; m_cnt = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
        end else if (bus.Rdy) begin
            if (code == 1) begin
                if (m_stk.size() == SD) begin
                    void'(m_stk.pop_back());
                    m_ovf = 1;
                end
                m_stk.push_front((m_pc + 1) & AMASK);
            end else if (code == 0) begin
                if (m_stk.size() == 0) m_unf = 1;
                else void'(m_stk.pop_front());
            end else if (code == 16) begin
                m_cnt = 32'(bus.BA) & CMASK;
            end else if (code == 17 && m_cnt != 0) begin
                m_cnt = m_cnt - 1;
            end
            m_pc = ma;
        end
        m_rstd = Rst;
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("MA",     32'(bus.MA),     exp_ma());
            chk("Via",    32'(bus.Via),    exp_via());
            chk("Cnt",    32'(bus.Cnt),    m_cnt);
            chk("CntZ",   32'(bus.CntZ),   32'(m_cnt == 0));
            chk("StkLvl", 32'(bus.StkLvl), m_stk.size());
            chk("StkOvf", 32'(bus.StkOvf), 32'(m_ovf));
            chk("StkUnf", 32'(bus.StkUnf), 32'(m_unf));
        end
    end

    task automatic apply(input logic [4:0] i, input logic [AW-1:0] ba, input logic rdy = 1'b1,
                         input logic rst = 1'b0, input logic [3:0] t = 4'd0, input logic [2:0] mw = 3'd0);
        @(posedge Clk);
        model_update();
        #1;
        bus.I = i; bus.BA = ba; bus.Rdy = rdy; bus.T = t; bus.MW = mw; Rst = rst;
        chk_en = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        Rst = 1'b1; bus.I = 5'd2; bus.BA = '0; bus.Rdy = 1'b1; bus.T = '0; bus.MW = '0;

        // Reset release with FTCH
        repeat (3) begin
            apply(5'd2, '0, 1'b1, 1'b1);
            chk("rst_MA", 32'(bus.MA), 0);
        end
        apply(5'd2, '0);
        chk("stretch_MA", 32'(bus.MA), 0);
        chk("rst_Cnt", 32'(bus.Cnt), 0);
        chk("rst_CntZ", 32'(bus.CntZ), 1);
        chk("rst_flags", {30'd0, bus.StkOvf, bus.StkUnf}, 0);
        for (int k = 1; k <= 3; k++) begin
            apply(5'd2, '0);
            chk("fetch_MA", 32'(bus.MA), k);
        end

        // Nested calls overflowing a 4-deep stack, then draining it
        apply(5'd4, 10'h010);
        chk("jump_MA", 32'(bus.MA), 'h10);
        for (int k = 0; k < 5; k++) apply(5'd1, 10'(32'h20 + k * 32'h10));
        apply(5'd0, '0);
        chk("ovf_set", 32'(bus.StkOvf), 1);
        chk("ovf_lvl", 32'(bus.StkLvl), 4);
        chk("rts1_MA", 32'(bus.MA), 'h51);
        apply(5'd0, '0); chk("rts2_MA", 32'(bus.MA), 'h41);
        apply(5'd0, '0); chk("rts3_MA", 32'(bus.MA), 'h31);
        apply(5'd0, '0); chk("rts4_MA", 32'(bus.MA), 'h21);
        apply(5'd0, '0); chk("rts5_MA", 32'(bus.MA), 0);

        // Counted loop: LDC 3 then DJNZ to itself
        apply(5'd16, 10'd3);
        chk("unf_set", 32'(bus.StkUnf), 1);
        chk("ldc_MA", 32'(bus.MA), 1);
        for (int k = 0; k < 4; k++) begin
            apply(5'd17, 10'd1);
            chk("djnz_Cnt", 32'(bus.Cnt), 3 - k);
            chk("djnz_MA", 32'(bus.MA), (k < 3) ? 1 : 2);
        end
        chk("djnz_CntZ", 32'(bus.CntZ), 1);
        apply(5'd2, '0);

        // BSR held across a stretched microcycle
        repeat (3) begin
            apply(5'd1, 10'h100, 1'b0);
            chk("stall_lvl", 32'(bus.StkLvl), 0);
            chk("stall_MA", 32'(bus.MA), 'h100);
        end
        apply(5'd1, 10'h100, 1'b1);
        apply(5'd2, '0);
        chk("stall_push_lvl", 32'(bus.StkLvl), 1);
        chk("stall_fetch_MA", 32'(bus.MA), 'h101);
        apply(5'd0, '0);
        chk("stall_ret_MA", 32'(bus.MA), 4);

        // Branch sweep
        for (int c = 3; c <= 15; c++) begin
            apply(5'(c), 10'h2A8, 1'b1, 1'b0, 4'b1010, 3'd5);
            if (c == 3)  chk("BMW_MA", 32'(bus.MA), 'h2AD);
            if (c == 15) chk("BMW3_MA", 32'(bus.MA), 'h2A9);
            if (c >= 4 && c <= 7) chk("BRV_Via", 32'(bus.Via), c - 4);
        end
        apply(5'h1F, 10'h2A8, 1'b1, 1'b0, 4'b1010, 3'd5);

        // Randomised traffic
        repeat (3000) begin
            int unsigned sel = $urandom_range(0, 9);
            logic [4:0] op;
            logic [AW-1:0] ba = AW'($urandom);
            if (sel < 2)       op = 5'd0;
            else if (sel < 4)  op = 5'd1;
            else if (sel == 4) begin op = 5'd16; ba = AW'($urandom_range(0, 5)); end
            else if (sel == 5) op = 5'd17;
            else               op = 5'($urandom_range(0, 31));
            apply(op, ba, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0),
                  4'($urandom), 3'($urandom));
        end

        @(posedge Clk);
        #1;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
